// File: rtl/async_evt_pkg.sv
// Shared types and default sizing for the asynchronous event arbiter.
// The pending-counter feature is selected by ASYNC_EVT_PENDCNT_EN (see async_event_arbiter).
package async_evt_pkg;

  localparam int unsigned N_CH_DEFAULT  = 4;
  localparam int unsigned CNT_W_DEFAULT = 3;

  typedef enum logic {
    IDLE,
    OFFER
  } arb_state_e;

  // Channel index following 'cur', wrapping from n_ch-1 back to 0.
  function automatic int unsigned rr_wrap(input int unsigned cur, input int unsigned step,
                                          input int unsigned n_ch);
    int unsigned sum;
    sum = cur + step;
    if (sum >= n_ch) sum = sum - n_ch;
    return sum;
  endfunction

endpackage

// File: rtl/event_sync.sv
// Two-flop synchronizer plus edge-detect flop; emits a one-cycle pulse per rising edge.
// Events are suppressed until the pipeline holds post-reset samples only.
module event_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;
  logic [2:0] arm_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  // arm_q[2] rises once sync3 holds a real sample, so a line high at release is not an edge.
  assign pulse = sync_q[1] & ~sync_q[2] & arm_q[2];

endmodule

// File: rtl/async_event_arbiter.sv
// Round-robin arbiter for asynchronous event lines with per-channel pending state.
// Define ASYNC_EVT_PENDCNT_EN for CNT_W-bit pending counters; otherwise 1-bit pending flags.
module async_event_arbiter
  import async_evt_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         async_in,
  output logic                    grant_valid,
  input  logic                    grant_ready,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic [N_CH-1:0]         pend_mask,
  output logic [N_CH-1:0]         overflow,
  input  logic [N_CH-1:0]         ovf_clr
);

`ifdef ASYNC_EVT_PENDCNT_EN
  localparam int unsigned CW = CNT_W;
`else
  // CNT_W is kept in the interface so both builds share one parameter set.
  localparam int unsigned CW = (CNT_W > 0) ? 1 : 1;
`endif
  localparam int unsigned ID_W = $clog2(N_CH);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] evt;
  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] ovf_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] win_id;
  arb_state_e      state_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    event_sync u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (async_in[g]),
      .pulse    (evt[g])
    );
  end

  // Pending counters: a coincident event and accept cancel out.
  always_comb begin
    cnt_d = cnt_q;
    drop  = '0;
    acc   = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc[i] = grant_valid && grant_ready && (grant_id == ID_W'(i));
      if (evt[i] && !acc[i]) begin
        if (cnt_q[i] == CNT_MAX) drop[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (acc[i] && !evt[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
    // A fresh drop wins over a same-cycle clear.
    ovf_d = drop | (overflow & ~ovf_clr);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      pend_mask[i] = |cnt_q[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '{default: '0};
      overflow <= '0;
    end else begin
      cnt_q    <= cnt_d;
      overflow <= ovf_d;
    end
  end

  // Scan from farthest to nearest so the nearest pending channel after rr_ptr_q wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_id = '0;
    idx    = '0;
    for (int unsigned k = N_CH; k >= 1; k--) begin
      idx = ID_W'(rr_wrap(32'(rr_ptr_q), k, N_CH));
      if (pend_mask[idx]) win_id = idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr_q    <= ID_W'(N_CH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|pend_mask) begin
            state_q     <= OFFER;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            state_q     <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr_q    <= grant_id;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed bench for async_event_arbiter (N_CH=4, CNT_W=3); table vectors plus corner sequences.
module tb_async_event_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] async_in = '0;
  logic       grant_valid;
  logic       grant_ready = 1'b0;
  logic [1:0] grant_id;
  logic [3:0] pend_mask;
  logic [3:0] overflow;
  logic [3:0] ovf_clr = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] first_id;
  } vec_t;

  vec_t vecs [6];

  async_event_arbiter #(
    .N_CH  (4),
    .CNT_W (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .async_in    (async_in),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_id    (grant_id),
    .pend_mask   (pend_mask),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    async_in    = '0;
    grant_ready = 1'b0;
    ovf_clr     = '0;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    int seen;
    int gc_a [8];
    logic [1:0] gid_a [8];

    // Hand-computed round-robin sequence starting from a fresh reset (last index 3).
    vecs[0] = '{mask: 4'b0100, first_id: 2'd2};
    vecs[1] = '{mask: 4'b1011, first_id: 2'd3};
    vecs[2] = '{mask: 4'b0101, first_id: 2'd2};
    vecs[3] = '{mask: 4'b0001, first_id: 2'd0};
    vecs[4] = '{mask: 4'b1111, first_id: 2'd1};
    vecs[5] = '{mask: 4'b1000, first_id: 2'd3};

    do_reset();
    check("reset_grant_valid", 32'(grant_valid), 32'd0);
    check("reset_grant_id", 32'(grant_id), 32'd0);
    check("reset_pend_mask", 32'(pend_mask), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // Single edge on channel 2: count at k+2, offer after k+3, held while not ready.
    async_in = 4'b0100;
    tick();
    tick();
    tick();
    check("ch2_valid_at_k2", 32'(grant_valid), 32'd0);
    check("ch2_pend_at_k2", 32'(pend_mask), 32'h4);
    tick();
    check("ch2_valid_at_k3", 32'(grant_valid), 32'd1);
    check("ch2_id_at_k3", 32'(grant_id), 32'd2);
    seen = 1;
    repeat (10) begin
      tick();
      if (!(grant_valid === 1'b1 && grant_id === 2'd2)) seen = 0;
    end
    check("ch2_held_10_cycles", 32'(seen), 32'd1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("ch2_valid_after_accept", 32'(grant_valid), 32'd0);
    check("ch2_pend_after_accept", 32'(pend_mask), 32'd0);
    async_in = '0;
    tick();

    do_reset();
    for (int v = 0; v < 6; v++) begin
      async_in = vecs[v].mask;
      tick();
      tick();
      async_in = '0;
      repeat (3) tick();
      check($sformatf("vec%0d_pend", v), 32'(pend_mask), 32'(vecs[v].mask));
      check($sformatf("vec%0d_valid", v), 32'(grant_valid), 32'd1);
      check($sformatf("vec%0d_first_id", v), 32'(grant_id), 32'(vecs[v].first_id));
      grant_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (pend_mask == 4'b0) break;
      end
      grant_ready = 1'b0;
      check($sformatf("vec%0d_drained", v), 32'(pend_mask), 32'd0);
      tick();
      check($sformatf("vec%0d_idle", v), 32'(grant_valid), 32'd0);
    end

    // All four channels at once, ready tied high: ids 0..3, one grant per two cycles.
    do_reset();
    grant_ready = 1'b1;
    async_in = 4'b1111;
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (grant_valid) begin
        if (n < 8) begin
          gid_a[n] = grant_id;
          gc_a[n]  = c;
        end
        n++;
      end
    end
    check("rr4_grant_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr4_id%0d", i), 32'(gid_a[i]), 32'(i));
    for (int i = 1; i < 4; i++) check($sformatf("rr4_gap%0d", i), 32'(gc_a[i] - gc_a[i-1]), 32'd2);
    grant_ready = 1'b0;
    async_in = '0;
    tick();

`ifdef ASYNC_EVT_PENDCNT_EN
    // Nine edges on channel 1 saturate a 3-bit counter at 7 and drop two.
    do_reset();
    for (int e = 0; e < 9; e++) begin
      async_in = 4'b0010;
      tick();
      tick();
      async_in = '0;
      tick();
      tick();
    end
    repeat (4) tick();
    check("sat_overflow", 32'(overflow), 32'h2);
    check("sat_pend", 32'(pend_mask), 32'h2);
    check("sat_id", 32'(grant_id), 32'd1);
    grant_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (pend_mask == 4'b0) break;
      if (grant_valid) n++;
      tick();
    end
    grant_ready = 1'b0;
    check("sat_accept_count", 32'(n), 32'd7);
    check("sat_pend_cleared", 32'(pend_mask), 32'd0);
`else
    // Two edges on channel 0 before any accept: flag saturates, second edge dropped.
    do_reset();
    for (int e = 0; e < 2; e++) begin
      async_in = 4'b0001;
      tick();
      tick();
      async_in = '0;
      tick();
      tick();
    end
    tick();
    tick();
    check("flag_overflow", 32'(overflow), 32'h1);
    check("flag_pend", 32'(pend_mask), 32'h1);
    check("flag_valid", 32'(grant_valid), 32'd1);
    check("flag_id", 32'(grant_id), 32'd0);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("flag_pend_after_accept", 32'(pend_mask), 32'd0);
    seen = 0;
    repeat (4) begin
      tick();
      if (grant_valid) seen = 1;
    end
    check("flag_single_grant", 32'(seen), 32'd0);
    check("flag_overflow_sticky", 32'(overflow), 32'h1);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = '0;
    check("flag_overflow_cleared", 32'(overflow), 32'd0);
`endif

    // Reset mid-offer kills the grant at once; a line held high through release is not an edge.
    do_reset();
    async_in = 4'b1000;
    repeat (4) tick();
    check("rst_pre_valid", 32'(grant_valid), 32'd1);
    check("rst_pre_id", 32'(grant_id), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(grant_valid), 32'd0);
    check("rst_async_pend", 32'(pend_mask), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (grant_valid || pend_mask != 4'b0) seen = 1;
    end
    check("rst_no_regrant", 32'(seen), 32'd0);
    async_in = '0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
